unified_mem_arbiter: RTL

- Shares one single-port BRAM (1-cycle registered read latency) between the instruction-fetch requester and the data load/store requester.
- Flat versions of the instruction and data memory master/slave signal sets.
- Slave side faces the core: stall/instr and stall/rd.
- Master side drives the BRAM.
- Round-robin arbitration on conflict; every access is 2 cycles (issue, respond).

---
 rtl/unified_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
//==============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port BRAM (1-cycle registered read) between
//               the instruction-fetch port and the data load/store port.
//               Every access takes two cycles (issue, respond). A fetch request
//               is implicitly present every cycle, so any cycle with d_en=1 is
//               a conflict, resolved round-robin.
// Ports       : clk, nrst            - clock, synchronous active-low reset
//               i_addr/i_instr/i_stall - instruction fetch slave
//               d_en/d_we/d_addr/d_wd/d_rd/d_stall - data slave
//               m_en/m_we/m_addr/m_wd/m_rd - BRAM master
//               perf_i_grant/perf_d_grant/perf_conflict - optional counters
// Options     : `define ARB_PERF_CNT_EN adds 32-bit saturating counters
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module unified_mem_arbiter #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_instr,
    output logic              i_stall,
    input  logic              d_en,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wd,
    output logic [31:0]       d_rd,
    output logic              d_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wd,
    input  logic [31:0]       m_rd
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_grant,
    output logic [31:0]       perf_d_grant,
    output logic [31:0]       perf_conflict
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_RESP = 2'd1,
        S_D_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_d;      // 1 = data port won the most recent grant
    logic        w_last_d_nxt;
    logic        r_d_wr;        // issued data access was a write
    logic [31:0] r_instr;
    logic [31:0] r_d_rd;
    logic        w_grant_d;
    logic        w_unused_addr;

    // Only bits [ADDR_W+1:2] select a word; the rest are intentionally dropped.
    assign w_unused_addr = ^{i_addr, d_addr};

    // Data wins unless it won last time; with no data request fetch always wins.
    assign w_grant_d = d_en && !r_last_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_last_d_nxt = r_last_d;
        m_en         = 1'b0;
        m_we         = 1'b0;
        m_addr       = i_addr[ADDR_W+1:2];
        m_wd         = d_wd;
        i_stall      = 1'b1;
        d_stall      = 1'b1;
        case (r_state)
            S_IDLE: begin
                m_en = 1'b1;
                if (w_grant_d) begin
                    m_we         = d_we;
                    m_addr       = d_addr[ADDR_W+1:2];
                    w_last_d_nxt = 1'b1;
                    w_state_nxt  = S_D_RESP;
                end else begin
                    w_last_d_nxt = 1'b0;
                    w_state_nxt  = S_I_RESP;
                end
            end
            S_I_RESP: begin
                i_stall     = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_D_RESP: begin
                d_stall     = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset suppresses BRAM activity and any in-flight completion.
        if (!nrst) begin
            m_en    = 1'b0;
            m_we    = 1'b0;
            i_stall = 1'b1;
            d_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_last_d <= 1'b0;
            r_d_wr   <= 1'b0;
            r_instr  <= 32'd0;
            r_d_rd   <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
            if (r_state == S_IDLE && w_grant_d) begin
                r_d_wr <= d_we;
            end
            if (r_state == S_I_RESP) begin
                r_instr <= m_rd;
            end
            if (r_state == S_D_RESP && !r_d_wr) begin
                r_d_rd <= m_rd;
            end
        end
    end

    // BRAM data is forwarded in the response cycle so it is valid together
    // with stall=0; the register holds it afterwards.
    assign i_instr = (r_state == S_I_RESP && nrst) ? m_rd : r_instr;
    assign d_rd    = (r_state == S_D_RESP && !r_d_wr && nrst) ? m_rd : r_d_rd;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_i_grant  <= 32'd0;
            perf_d_grant  <= 32'd0;
            perf_conflict <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (!w_grant_d && perf_i_grant != 32'hFFFF_FFFF) begin
                perf_i_grant <= perf_i_grant + 32'd1;
            end
            if (w_grant_d && perf_d_grant != 32'hFFFF_FFFF) begin
                perf_d_grant <= perf_d_grant + 32'd1;
            end
            if (d_en && perf_conflict != 32'hFFFF_FFFF) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
